// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (5..8 data bits, optional parity, one or two stop bits).
// Define UART_RX_BREAK_DETECT_EN to add the break_det output and suppress delivery of break frames.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rx,
  input  logic [1:0] data_bits_count,
  input  logic [1:0] parity_type,
  input  logic       double_stop_bits,
  output logic [7:0] dout,
  output logic       valid,
  input  logic       ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic       break_det
`endif
);

  localparam int LP_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  logic [LP_STAGES-1:0] r_sync;
  logic                 w_rx;

  state_t     r_state, w_state_next;
  logic [3:0] r_tick, w_tick_next;
  logic [2:0] r_bit, w_bit_next;
  logic [7:0] r_shift, w_shift_next;
  logic [1:0] r_nbits, w_nbits_next;
  logic [1:0] r_ptype, w_ptype_next;
  logic       r_dstop, w_dstop_next;
  logic       r_perr, w_perr_next;
  logic       r_ferr, w_ferr_next;
  logic       r_zero, w_zero_next;
  logic       w_sample;
  logic       w_done;
  logic       w_brk;

  logic [7:0] r_dout;
  logic       r_valid;
  logic       r_parity_err;
  logic       r_frame_err;
  logic       r_overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[LP_STAGES-2:0], rx};
    end
  end

  assign w_rx = r_sync[LP_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_tick  <= 4'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_nbits <= 2'd0;
      r_ptype <= 2'd0;
      r_dstop <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tick  <= w_tick_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_nbits <= w_nbits_next;
      r_ptype <= w_ptype_next;
      r_dstop <= w_dstop_next;
      r_perr  <= w_perr_next;
      r_ferr  <= w_ferr_next;
      r_zero  <= w_zero_next;
    end
  end

  // Bit samples fall on the tick where the counter sits at 15; the increment wraps it to 0.
  assign w_sample = sample_tick && (r_tick == 4'd15);

  always_comb begin
    w_state_next = r_state;
    w_tick_next  = sample_tick ? (r_tick + 4'd1) : r_tick;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_nbits_next = r_nbits;
    w_ptype_next = r_ptype;
    w_dstop_next = r_dstop;
    w_perr_next  = r_perr;
    w_ferr_next  = r_ferr;
    w_zero_next  = r_zero;
    w_done       = 1'b0;

    case (r_state)
      IDLE: begin
        w_tick_next = 4'd0;
        if (sample_tick && !w_rx) begin
          w_state_next = START;
        end
      end
      START: begin
        if (sample_tick && (r_tick == 4'd7)) begin
          w_tick_next = 4'd0;
          if (w_rx) begin
            w_state_next = IDLE;
          end else begin
            w_state_next = DATA;
            w_nbits_next = data_bits_count;
            w_ptype_next = parity_type;
            w_dstop_next = double_stop_bits;
            w_bit_next   = 3'd0;
            w_shift_next = 8'd0;
            w_perr_next  = 1'b0;
            w_ferr_next  = 1'b0;
            w_zero_next  = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_sample) begin
          w_shift_next[r_bit] = w_rx;
          w_bit_next          = r_bit + 3'd1;
          if (r_bit == ({1'b0, r_nbits} + 3'd4)) begin
            w_state_next = ((r_ptype == 2'b01) || (r_ptype == 2'b10)) ? PARITY : STOP1;
          end
        end
      end
      PARITY: begin
        if (w_sample) begin
          // Even: data^parity must be 0; odd: must be 1.
          w_perr_next  = (^r_shift) ^ w_rx ^ r_ptype[1];
          w_zero_next  = r_zero & ~w_rx;
          w_state_next = STOP1;
        end
      end
      STOP1: begin
        if (w_sample) begin
          w_ferr_next = r_ferr | ~w_rx;
          w_zero_next = r_zero & ~w_rx;
          if (r_dstop) begin
            w_state_next = STOP2;
          end else begin
            w_state_next = IDLE;
            w_done       = 1'b1;
          end
        end
      end
      STOP2: begin
        if (w_sample) begin
          w_ferr_next  = r_ferr | ~w_rx;
          w_zero_next  = r_zero & ~w_rx;
          w_state_next = IDLE;
          w_done       = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

`ifdef UART_RX_BREAK_DETECT_EN
  assign w_brk = w_done && w_zero_next && (r_shift == 8'd0);
`else
  assign w_brk = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout       <= 8'd0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done && !w_brk) begin
        if (!r_valid || ready) begin
          r_dout       <= r_shift;
          r_parity_err <= w_perr_next;
          r_frame_err  <= w_ferr_next;
          r_valid      <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic r_break_det;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_break_det <= 1'b0;
    end else begin
      r_break_det <= w_brk;
    end
  end

  assign break_det = r_break_det;
`endif

  assign dout       = r_dout;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + randomized frames for uart_rx, checked against a frame-level model.
// Build with UART_RX_BREAK_DETECT_EN defined to exercise break detection.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] data_bits_count = 2'd3;
  logic [1:0] parity_type = 2'd0;
  logic       double_stop_bits = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] dout;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       break_det;
`endif

  int total = 0;
  int bad = 0;
  int n_valid_cyc = 0;
  int n_ovr = 0;
  int n_brk = 0;
  int brk_base = 0;
  int tick_div = 0;
  logic [9:0] q_got[$];

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .sample_tick      (sample_tick),
    .rx               (rx),
    .data_bits_count  (data_bits_count),
    .parity_type      (parity_type),
    .double_stop_bits (double_stop_bits),
    .dout             (dout),
    .valid            (valid),
    .ready            (ready),
    .parity_err       (parity_err),
    .frame_err        (frame_err),
    .overrun          (overrun),
    .busy             (busy)
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    .break_det        (break_det)
`endif
  );

  always #5 clk = ~clk;

  // 16x tick every fourth clock, launched on the falling edge
  always @(negedge clk) begin
    tick_div = (tick_div + 1) % 4;
    sample_tick = (tick_div == 0);
  end

  // Handshakes seen here complete on the following rising edge
  always @(negedge clk) begin
    if (valid) n_valid_cyc++;
    if (valid && ready) q_got.push_back({frame_err, parity_err, dout});
    if (overrun) n_ovr++;
`ifdef UART_RX_BREAK_DETECT_EN
    if (break_det) n_brk++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!sample_tick) @(posedge clk);
    end
    #1;
  endtask

  // Returns {break, frame_err, parity_err, dout} for one frame as placed on the line
  function automatic logic [10:0] model(input logic [7:0] d, input int nb, input logic [1:0] pt,
                                        input logic pbit, input logic s1, input logic s2,
                                        input logic ds);
    logic [7:0] m;
    int         ones;
    logic       par_on, perr, ferr, brk;
    m = 8'd0;
    for (int i = 0; i < nb; i++) m[i] = d[i];
    par_on = (pt == 2'b01) || (pt == 2'b10);
    ones   = $countones(m) + (pbit ? 1 : 0);
    perr   = par_on && ((pt == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0));
    ferr   = !s1 || (ds && !s2);
    brk    = (m == 8'd0) && (!par_on || !pbit) && !s1 && (!ds || !s2);
    return {brk, ferr, perr, m};
  endfunction

  task automatic send_frame(input logic [7:0] d, input int nb, input logic [1:0] pt,
                            input logic pbit, input logic s1, input logic s2, input logic ds);
    q_got.delete();
    brk_base = n_brk;
    data_bits_count  = 2'(nb - 5);
    parity_type      = pt;
    double_stop_bits = ds;
    rx = 1'b0;
    wait_ticks(16);
    // Frame settings are already captured; scramble them to prove it
    data_bits_count  = 2'($urandom);
    parity_type      = 2'($urandom);
    double_stop_bits = 1'($urandom);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    if ((pt == 2'b01) || (pt == 2'b10)) begin
      rx = pbit;
      wait_ticks(16);
    end
    rx = s1;
    wait_ticks(16);
    if (ds) begin
      rx = s2;
      wait_ticks(16);
    end
    rx = 1'b1;
    wait_ticks(24);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d, input int nb,
                             input logic [1:0] pt, input logic pbit, input logic s1,
                             input logic s2, input logic ds);
    logic [10:0] e;
    logic [9:0]  g;
    e = model(d, nb, pt, pbit, s1, s2, ds);
    g = '1;
    $display("frame %s: sent=%02h nb=%0d pt=%0d pbit=%0d s1=%0d s2=%0d ds=%0d -> exp dout=%02h perr=%0d ferr=%0d brk=%0d",
             tag, d, nb, pt, pbit, s1, s2, ds, e[7:0], e[8], e[9], e[10]);
`ifdef UART_RX_BREAK_DETECT_EN
    if (e[10]) begin
      chk({tag, ".brk"}, 32'(n_brk - brk_base), 32'd1);
      chk({tag, ".nq"}, 32'(q_got.size()), 32'd0);
    end else begin
`endif
      chk({tag, ".nq"}, 32'(q_got.size()), 32'd1);
      if (q_got.size() > 0) g = q_got.pop_front();
      chk({tag, ".dout"}, 32'(g[7:0]), 32'(e[7:0]));
      chk({tag, ".perr"}, 32'(g[8]), 32'(e[8]));
      chk({tag, ".ferr"}, 32'(g[9]), 32'(e[9]));
`ifdef UART_RX_BREAK_DETECT_EN
    end
`endif
  endtask

  initial begin
    logic [7:0] d;
    int         nb;
    logic [1:0] pt;
    logic       pbit, s1, s2, ds;

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.dout", 32'(dout), 32'h00);
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.perr", 32'(parity_err), 32'd0);
    chk("rst.ferr", 32'(frame_err), 32'd0);
    chk("rst.overrun", 32'(overrun), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    reset = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5, valid for exactly one cycle under ready=1
    n_valid_cyc = 0;
    send_frame(8'hA5, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("a5_8n1", 8'hA5, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("a5.valid_cycles", 32'(n_valid_cyc), 32'd1);

    // 5 bits even parity, 0x1F with parity bit 0
    send_frame(8'h1F, 5, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("1f_5e1", 8'h1F, 5, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);

    // 7 bits odd parity, correct parity bit
    send_frame(8'h6B, 7, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("6b_7o1", 8'h6B, 7, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);

    // False start: 5-tick low pulse
    n_valid_cyc = 0;
    q_got.delete();
    rx = 1'b0;
    wait_ticks(5);
    rx = 1'b1;
    wait_ticks(2);
    chk("fs.busy_during", 32'(busy), 32'd1);
    wait_ticks(20);
    chk("fs.busy_after", 32'(busy), 32'd0);
    chk("fs.valid_cycles", 32'(n_valid_cyc), 32'd0);
    chk("fs.nq", 32'(q_got.size()), 32'd0);
    $display("false start: busy=%0d valid_cycles=%0d", busy, n_valid_cyc);

    // Two stop bits, second one low
    send_frame(8'h3C, 8, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    check_frame("3c_8n2_bad", 8'h3C, 8, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);

    // Randomized frames
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      nb   = 5 + int'($urandom_range(0, 3));
      pt   = 2'($urandom);
      pbit = 1'($urandom);
      ds   = 1'($urandom);
      s1   = ($urandom_range(0, 4) != 0);
      s2   = ($urandom_range(0, 4) != 0);
      send_frame(d, nb, pt, pbit, s1, s2, ds);
      check_frame($sformatf("rnd%0d", i), d, nb, pt, pbit, s1, s2, ds);
    end

    // Consumer stalled: second frame overruns
    ready = 1'b0;
    n_ovr = 0;
    send_frame(8'h11, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovr.valid1", 32'(valid), 32'd1);
    chk("ovr.dout1", 32'(dout), 32'h11);
    chk("ovr.none_yet", 32'(n_ovr), 32'd0);
    send_frame(8'h22, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovr.pulse_cycles", 32'(n_ovr), 32'd1);
    chk("ovr.valid2", 32'(valid), 32'd1);
    chk("ovr.dout2", 32'(dout), 32'h11);
    ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr.valid_drop", 32'(valid), 32'd0);
    chk("ovr.dout_hold", 32'(dout), 32'h11);
    chk("ovr.nq", 32'(q_got.size()), 32'd1);
    chk("ovr.accepted", 32'(q_got.size() > 0 ? q_got[0][7:0] : 8'hFF), 32'h11);
    $display("overrun: pulses=%0d accepted=%0d", n_ovr, q_got.size());

    // Reset during data bits of 0x55, then a clean 0x66
    q_got.delete();
    n_valid_cyc = 0;
    data_bits_count  = 2'd3;
    parity_type      = 2'd0;
    double_stop_bits = 1'b0;
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16);
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(8);
    chk("mid.busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #2;
    chk("mid.busy_rst", 32'(busy), 32'd0);
    chk("mid.valid_rst", 32'(valid), 32'd0);
    #20;
    reset = 1'b1;
    wait_ticks(20);
    chk("mid.valid_cycles", 32'(n_valid_cyc), 32'd0);
    chk("mid.busy_idle", 32'(busy), 32'd0);
    $display("reset mid-frame: valid_cycles=%0d", n_valid_cyc);
    send_frame(8'h66, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("66_after_rst", 8'h66, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);

    // All-zero frame (break)
    n_valid_cyc = 0;
    send_frame(8'h00, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    check_frame("zero", 8'h00, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, number of rx synchronizer flops (min 2).
REQ-002 SHALL provide port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port sample_tick  input  1  16x-baud strobe, one clk cycle wide.
REQ-005 SHALL provide port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL provide port data_bits_count  input  2  data bits = value + 5 (5..8).
REQ-007 SHALL provide port parity_type  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-008 SHALL provide port double_stop_bits  input  1  1 = two stop bits checked.
REQ-009 SHALL provide port dout  output  8  received byte, LSB-aligned, unused upper bits 0.
REQ-010 SHALL provide port valid  output  1  dout/status hold a received frame.
REQ-011 SHALL provide port ready  input  1  consumer (rx FIFO) accepts frame when valid && ready.
REQ-012 SHALL provide ports parity_err, frame_err  output  1 each  per-frame flags, qualified by valid.
REQ-013 SHALL provide port overrun  output  1  one-cycle pulse, frame lost.
REQ-014 SHALL provide port busy  output  1  high in any state except IDLE.

Function
REQ-015 rx SHALL pass through SYNC_STAGES flops (reset value 1) before any use.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2; a 4-bit tick counter advances only on sample_tick.
REQ-017 IDLE: synchronized rx == 0 on a sample_tick SHALL enter START with tick counter cleared.
REQ-018 START: at tick count 7 (mid-bit) rx == 1 SHALL return to IDLE (false start, no output); rx == 0 SHALL latch data_bits_count, parity_type, double_stop_bits and enter DATA, counter cleared.
REQ-019 Config changes after START confirmation SHALL not affect the frame in progress.
REQ-020 DATA/PARITY/STOP1/STOP2: each bit SHALL be sampled when counter reaches 15 (16 ticks after previous sample), counter wraps to 0.
REQ-021 DATA SHALL shift bits LSB first; after latched count bits go to PARITY if parity enabled, else STOP1.
REQ-022 PARITY: parity_err SHALL be set if data XOR sampled bit mismatches even (01) / odd (10) rule.
REQ-023 STOP1/STOP2: sampled 0 SHALL set frame_err; STOP1 goes to STOP2 if double stop latched, else frame completes.
REQ-024 On frame completion SHALL return to IDLE in the same cycle so the next start edge is seen without a gap.
REQ-025 Completion with valid == 0, or valid && ready in the same cycle, SHALL load dout/flags and assert valid next cycle; no overrun.
REQ-026 Completion with valid && !ready SHALL discard the new frame, keep old dout/flags, pulse overrun one cycle.
REQ-027 valid && ready without completion SHALL deassert valid next cycle; dout holds its value.

Reset
REQ-028 reset low SHALL asynchronously force IDLE, counter 0, synchronizer 1s, dout 0, valid 0, parity_err 0, frame_err 0, overrun 0, busy 0.
REQ-029 reset mid-frame SHALL abandon the frame with no output; after release reception restarts on next falling edge.

Configuration
REQ-030 Macro UART_RX_BREAK_DETECT_EN defined: SHALL add output break_det (1 bit, reset 0), one-cycle pulse when a completed frame has all data, parity and stop samples 0; that frame SHALL not be loaded nor set valid.
REQ-031 Macro undefined: break_det SHALL not exist; all-zero frame SHALL be delivered as dout 0 with frame_err 1.

Verification
REQ-032 8N1, rx frames 0xA5, ready=1 -> valid one cycle, dout 0xA5, parity_err 0, frame_err 0.
REQ-033 data_bits_count=00, parity 01, send 0x1F with parity bit 0 -> dout 0x1F, parity_err 1.
REQ-034 rx low pulse of 5 ticks in IDLE -> returns IDLE, valid never asserts, busy falls.
REQ-035 ready=0, send 0x11 then 0x22 -> valid held, dout 0x11, overrun pulse at 0x22 completion.
REQ-036 double_stop_bits=1, second stop bit 0, data 0x3C -> dout 0x3C, frame_err 1.
REQ-037 reset low during DATA of 0x55, release, send 0x66 -> only dout 0x66 delivered; with UART_RX_BREAK_DETECT_EN, all-zero frame -> break_det pulse, valid 0.
